decode_queue: RTL and testbench

Parametrised decode stage with an elastic instruction buffer between fetch and execute. Each accepted fetch bundle is decoded on entry by the existing `decoder`/`immgen` logic. The resulting bundle is stored in a circular buffer of `DEPTH` entries: control, source register addresses, pc, immediate and CSR address. Execute pops bundles with a valid/ready handshake. Fetch and execute are decoupled, so a stalled execute no longer freezes fetch immediately, and a redirect flushes all buffered instructions.

---
 rtl/decode_queue.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_decode_queue.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// -----------------------------------------------------------------------------
// decode_queue_pkg / decode_queue
//
// Decode stage with an elastic instruction buffer between fetch and execute.
// Every fetch bundle the queue accepts is decoded on entry by the decoder and
// immgen functions. The decoded bundle is stored in a circular buffer of DEPTH
// entries, and execute pops bundles with a valid/ready handshake. A flush
// (redirect) discards everything that is buffered or arriving.
//
// Parameters
//   DEPTH   buffer entries (power of two, >= 2)
//   CNT_W   occupancy counter width (derived, do not override)
//
// Ports
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   in_valid    fetch offers in_data
//   in_data     fetch bundle {raw_instr, pc, valid, instr_misalign}
//   in_ready    buffer can accept this cycle (never depends on out_ready)
//   flush       redirect: drop stored and incoming instructions
//   out_valid   head bundle available
//   out_ready   execute consumes the head
//   out_ctl     decoded control
//   out_ra1/2   source registers, zero when the source is unused
//   out_pc      instruction pc
//   out_imm     generated immediate
//   out_csr_ra  CSR address (same as out_ctl.csr.csr)
//   count       current occupancy
//   All out_* payload outputs are zero whenever out_valid is low.
//
// Build option
//   DECODE_QUEUE_BYPASS_EN  when defined, an instruction arriving at an empty
//                           buffer appears on out_* in the same cycle and is
//                           not stored if execute takes it at once.
// -----------------------------------------------------------------------------
package decode_queue_pkg;

    typedef logic [63:0] u64;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [11:0] csr_addr_t;

    typedef struct packed {
        logic [31:0] raw_instr;
        u64          pc;
        logic        valid;
        logic        instr_misalign;
    } fetch_data_t;

    typedef struct packed {
        logic      en;
        logic [2:0] op;
        csr_addr_t csr;
    } csr_ctl_t;

    typedef struct packed {
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic       funct7_5;
        creg_addr_t rd;
        logic       rdEn;
        logic       ra1En;
        logic       ra2En;
        logic       illegal;
        logic       instr_misalign;
        csr_ctl_t   csr;
    } control_t;

    typedef enum logic [6:0] {
        OPC_LOAD      = 7'b0000011,
        OPC_MISC_MEM  = 7'b0001111,
        OPC_OP_IMM    = 7'b0010011,
        OPC_AUIPC     = 7'b0010111,
        OPC_OP_IMM_32 = 7'b0011011,
        OPC_STORE     = 7'b0100011,
        OPC_OP        = 7'b0110011,
        OPC_LUI       = 7'b0110111,
        OPC_OP_32     = 7'b0111011,
        OPC_BRANCH    = 7'b1100011,
        OPC_JALR      = 7'b1100111,
        OPC_JAL       = 7'b1101111,
        OPC_SYSTEM    = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z
    } imm_fmt_e;

    // CSR instructions are SYSTEM with funct3[1:0] != 0; funct3[2] selects
    // the immediate (zimm) form, which has no source register.
    function automatic logic is_csr(input logic [31:0] instr);
        return (instr[6:0] == OPC_SYSTEM) && (instr[13:12] != 2'b00);
    endfunction

    // A misaligned fetch carries no usable instruction bits, so only the
    // exception tag is raised and every other field stays zero.
    function automatic control_t decoder(input logic [31:0] instr,
                                         input logic        instr_misalign);
        control_t c;
        c = '0;
        if (instr_misalign) begin
            c.instr_misalign = 1'b1;
        end else begin
            c.opcode   = instr[6:0];
            c.funct3   = instr[14:12];
            c.funct7_5 = instr[30];
            case (instr[6:0])
                OPC_LUI, OPC_AUIPC, OPC_JAL: c.rdEn = 1'b1;
                OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32: begin
                    c.rdEn  = 1'b1;
                    c.ra1En = 1'b1;
                end
                OPC_BRANCH, OPC_STORE: begin
                    c.ra1En = 1'b1;
                    c.ra2En = 1'b1;
                end
                OPC_OP, OPC_OP_32: begin
                    c.rdEn  = 1'b1;
                    c.ra1En = 1'b1;
                    c.ra2En = 1'b1;
                end
                OPC_SYSTEM: begin
                    if (is_csr(instr)) begin
                        c.rdEn    = 1'b1;
                        c.ra1En   = !instr[14];
                        c.csr.en  = 1'b1;
                        c.csr.op  = instr[14:12];
                        c.csr.csr = instr[31:20];
                    end
                end
                OPC_MISC_MEM: ;
                default: c.illegal = 1'b1;
            endcase
            c.rd = c.rdEn ? instr[11:7] : '0;
        end
        return c;
    endfunction

    function automatic imm_fmt_e imm_fmt(input logic [31:0] instr);
        imm_fmt_e f;
        case (instr[6:0])
            OPC_LOAD, OPC_JALR, OPC_OP_IMM, OPC_OP_IMM_32: f = IMM_I;
            OPC_STORE:                                     f = IMM_S;
            OPC_BRANCH:                                    f = IMM_B;
            OPC_LUI, OPC_AUIPC:                            f = IMM_U;
            OPC_JAL:                                       f = IMM_J;
            OPC_SYSTEM: f = (is_csr(instr) && instr[14]) ? IMM_Z : IMM_NONE;
            default:                                       f = IMM_NONE;
        endcase
        return f;
    endfunction

    function automatic u64 immgen(input logic [31:0] instr,
                                  input logic        instr_misalign);
        u64 imm;
        imm = '0;
        if (!instr_misalign) begin
            case (imm_fmt(instr))
                IMM_I: imm = {{52{instr[31]}}, instr[31:20]};
                IMM_S: imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
                IMM_B: imm = {{51{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
                IMM_U: imm = {{32{instr[31]}}, instr[31:12], 12'b0};
                IMM_J: imm = {{43{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0};
                IMM_Z: imm = {59'b0, instr[19:15]};
                default: imm = '0;
            endcase
        end
        return imm;
    endfunction

endpackage

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  fetch_data_t      in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output control_t         out_ctl,
    output creg_addr_t       out_ra1,
    output creg_addr_t       out_ra2,
    output u64               out_pc,
    output u64               out_imm,
    output csr_addr_t        out_csr_ra,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        control_t   ctl;
        creg_addr_t ra1;
        creg_addr_t ra2;
        u64         pc;
        u64         imm;
    } entry_t;

    entry_t           mem_q [DEPTH];
    ptr_t             wptr_q, wptr_d;
    ptr_t             rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    entry_t dec_entry;
    entry_t head_entry;
    logic   push;
    logic   pop;
    logic   wr_en;
    logic   rd_en;
    logic   bypass_active;

    // Decode is purely combinational on the incoming bundle.
    always_comb begin
        dec_entry.ctl = decoder(in_data.raw_instr, in_data.instr_misalign);
        dec_entry.ra1 = dec_entry.ctl.ra1En ? in_data.raw_instr[19:15] : '0;
        dec_entry.ra2 = dec_entry.ctl.ra2En ? in_data.raw_instr[24:20] : '0;
        dec_entry.pc  = in_data.pc;
        dec_entry.imm = immgen(in_data.raw_instr, in_data.instr_misalign);
    end

    // in_ready looks only at local occupancy, so execute stalls never reach
    // fetch combinationally; a full buffer refuses even if it is popped now.
    assign in_ready = resetn && (count_q < CNT_W'(DEPTH));

    // A bubble (in_data.valid == 0) completes the handshake but stores nothing.
    assign push = in_valid && in_ready && !flush && in_data.valid;

`ifdef DECODE_QUEUE_BYPASS_EN
    // in_ready folds in resetn so nothing is presented while in reset.
    assign bypass_active = in_ready && (count_q == '0) && in_valid &&
                           in_data.valid && !flush;
`else
    assign bypass_active = 1'b0;
`endif

    assign out_valid = bypass_active || ((count_q != '0) && !flush);
    assign pop       = out_valid && out_ready;

    // A bypassed bundle taken by execute in the same cycle is never stored;
    // the storage side cannot pop while bypassing because it is empty.
    assign wr_en = push && !(bypass_active && out_ready);
    assign rd_en = pop && !bypass_active;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + ptr_t'(1);
            if (rd_en) rptr_d = rptr_q + ptr_t'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only observable
    // through count, which is reset, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= dec_entry;
        end
    end

    assign head_entry = bypass_active ? dec_entry : mem_q[rptr_q];

    always_comb begin
        out_ctl = '0;
        out_ra1 = '0;
        out_ra2 = '0;
        out_pc  = '0;
        out_imm = '0;
        if (out_valid) begin
            out_ctl = head_entry.ctl;
            out_ra1 = head_entry.ra1;
            out_ra2 = head_entry.ra2;
            out_pc  = head_entry.pc;
            out_imm = head_entry.imm;
        end
    end

    assign out_csr_ra = out_ctl.csr.csr;
    assign count      = count_q;

endmodule

// File: tb/tb_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_decode_queue
//
// Self-checking bench for decode_queue. A reference model keeps the buffered
// instructions in a queue and decodes RV64I bundles from the instruction
// format rules with plain arithmetic. Directed scenarios cover reset, fill to
// full, streaming, flush, bubbles and misaligned fetches; randomized traffic
// with an asynchronous reset in the middle follows.
// -----------------------------------------------------------------------------
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef DECODE_QUEUE_BYPASS_EN
    localparam int STREAM_COUNT = 0;
`else
    localparam int STREAM_COUNT = 1;
`endif

    logic             clk;
    logic             resetn;
    logic             in_valid;
    fetch_data_t      in_data;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    control_t         out_ctl;
    creg_addr_t       out_ra1;
    creg_addr_t       out_ra2;
    u64               out_pc;
    u64               out_imm;
    csr_addr_t        out_csr_ra;
    logic [CNT_W-1:0] count;

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctl    (out_ctl),
        .out_ra1    (out_ra1),
        .out_ra2    (out_ra2),
        .out_pc     (out_pc),
        .out_imm    (out_imm),
        .out_csr_ra (out_csr_ra),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        control_t   ctl;
        creg_addr_t ra1;
        creg_addr_t ra2;
        u64         pc;
        u64         imm;
    } exp_t;

    exp_t q[$];
    int   n_vec;
    int   n_fail;
    logic exp_ready;
    logic exp_valid;
    logic exp_bypass;
    exp_t exp_head;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode from the RISC-V format rules.
    function automatic exp_t ref_decode(input logic [31:0] raw, input u64 pc,
                                        input logic mis);
        exp_t       e;
        int signed  w;
        longint     sgn;
        logic       rd_u, rs1_u, rs2_u;
        byte        fmt;
        e     = '0;
        e.pc  = pc;
        if (mis) begin
            e.ctl.instr_misalign = 1'b1;
            return e;
        end
        e.ctl.opcode   = raw[6:0];
        e.ctl.funct3   = raw[14:12];
        e.ctl.funct7_5 = raw[30];
        rd_u = 0; rs1_u = 0; rs2_u = 0; fmt = "-";
        case (raw[6:0])
            7'h37, 7'h17:               begin rd_u = 1; fmt = "U"; end
            7'h6F:                      begin rd_u = 1; fmt = "J"; end
            7'h67, 7'h03, 7'h13, 7'h1B: begin rd_u = 1; rs1_u = 1; fmt = "I"; end
            7'h63:                      begin rs1_u = 1; rs2_u = 1; fmt = "B"; end
            7'h23:                      begin rs1_u = 1; rs2_u = 1; fmt = "S"; end
            7'h33, 7'h3B:               begin rd_u = 1; rs1_u = 1; rs2_u = 1; end
            7'h0F: ;
            7'h73: begin
                if (raw[13:12] != 2'b00) begin
                    rd_u          = 1;
                    rs1_u         = !raw[14];
                    fmt           = raw[14] ? "Z" : "-";
                    e.ctl.csr.en  = 1'b1;
                    e.ctl.csr.op  = raw[14:12];
                    e.ctl.csr.csr = raw[31:20];
                end
            end
            default: e.ctl.illegal = 1'b1;
        endcase
        e.ctl.rdEn  = rd_u;
        e.ctl.ra1En = rs1_u;
        e.ctl.ra2En = rs2_u;
        e.ctl.rd    = rd_u  ? raw[11:7]  : 5'd0;
        e.ra1       = rs1_u ? raw[19:15] : 5'd0;
        e.ra2       = rs2_u ? raw[24:20] : 5'd0;
        w   = raw;
        sgn = longint'(w >>> 31);
        case (fmt)
            "I": e.imm = longint'(w >>> 20);
            "S": e.imm = longint'(w >>> 25) * 32 + longint'(raw[11:7]);
            "B": e.imm = sgn * 4096 + longint'(raw[7]) * 2048 +
                         longint'(raw[30:25]) * 32 + longint'(raw[11:8]) * 2;
            "U": e.imm = longint'(w >>> 12) * 4096;
            "J": e.imm = sgn * 1048576 + longint'(raw[19:12]) * 4096 +
                         longint'(raw[20]) * 2048 + longint'(raw[30:21]) * 2;
            "Z": e.imm = longint'(raw[19:15]);
            default: e.imm = 64'd0;
        endcase
        return e;
    endfunction

    // Apply inputs just after a falling edge, then compare every output.
    task automatic drive(input logic iv, input logic [31:0] raw, input u64 pc,
                         input logic v, input logic mis, input logic fl,
                         input logic ordy);
        in_valid               = iv;
        in_data.raw_instr      = raw;
        in_data.pc             = pc;
        in_data.valid          = v;
        in_data.instr_misalign = mis;
        flush                  = fl;
        out_ready              = ordy;
        #1;
        exp_ready = resetn && (q.size() < DEPTH);
`ifdef DECODE_QUEUE_BYPASS_EN
        exp_bypass = resetn && (q.size() == 0) && iv && v && !fl;
`else
        exp_bypass = 1'b0;
`endif
        exp_valid = exp_bypass || ((q.size() != 0) && !fl);
        if (!exp_valid)      exp_head = '0;
        else if (exp_bypass) exp_head = ref_decode(raw, pc, mis);
        else                 exp_head = q[0];
        check("in_ready",   64'(in_ready),   64'(exp_ready));
        check("out_valid",  64'(out_valid),  64'(exp_valid));
        check("count",      64'(count),      64'(q.size()));
        check("out_ctl",    64'(out_ctl),    64'(exp_head.ctl));
        check("out_ra1",    64'(out_ra1),    64'(exp_head.ra1));
        check("out_ra2",    64'(out_ra2),    64'(exp_head.ra2));
        check("out_pc",     out_pc,          exp_head.pc);
        check("out_imm",    out_imm,         exp_head.imm);
        check("out_csr_ra", 64'(out_csr_ra), 64'(exp_head.ctl.csr.csr));
    endtask

    // Advance one clock and update the model with the handshake rules.
    task automatic tick();
        @(posedge clk);
        if (!resetn || flush) begin
            q.delete();
        end else if (!(exp_bypass && out_ready)) begin
            if (exp_valid && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready && in_data.valid)
                q.push_back(ref_decode(in_data.raw_instr, in_data.pc,
                                       in_data.instr_misalign));
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0, ordy);
    endtask

    logic [6:0] opcs [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23,
                              7'h33, 7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(9) == 0) return r;
        return {r[31:7], opcs[$urandom_range(12)]};
    endfunction

    initial begin
        n_vec     = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset held for three cycles, then a single addi.
        repeat (3) begin idle(1'b0); tick(); end
        resetn = 1'b1;
        drive(1'b1, 32'h00510093, 64'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        check("addi_valid", 64'(out_valid), 64'd1);
        check("addi_ra1",   64'(out_ra1),   64'd2);
        check("addi_ra2",   64'(out_ra2),   64'd0);
        check("addi_imm",   out_imm,        64'd5);
        check("addi_pc",    out_pc,         64'h8000_0000);
        tick();
        idle(1'b0);
        check("addi_popped_count", 64'(count), 64'd0);
        tick();

        // Fill to full with execute stalled, then offer a fifth.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, rand_instr(), 64'(4 * i), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, rand_instr(), 64'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        check("full_count",    64'(count),    64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b1);
            check($sformatf("drain_pc%0d", i), out_pc, 64'(4 * i));
            tick();
        end
        idle(1'b0);
        check("drained_count", 64'(count), 64'd0);
        tick();

        // Continuous stream with both sides ready.
        for (int i = 0; i < 21; i++) begin
            drive(1'b1, rand_instr(), 64'h1000 + 64'(4 * i), 1'b1, 1'b0,
                  1'b0, 1'b1);
            if (i > 0) check($sformatf("stream_count%0d", i), 64'(count),
                             64'(STREAM_COUNT));
            tick();
        end
        idle(1'b1); tick();

        // Flush a full buffer while offering a push and a pop.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, rand_instr(), 64'h2000 + 64'(4 * i), 1'b1, 1'b0,
                  1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h00510093, 64'h2100, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        idle(1'b1);
        check("flush_full_count", 64'(count),     64'd0);
        check("flush_full_valid", 64'(out_valid), 64'd0);
        tick();
        // Flush with room to spare: the offered push must still be dropped.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, rand_instr(), 64'h2200 + 64'(4 * i), 1'b1, 1'b0,
                  1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h00510093, 64'h2300, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        idle(1'b1);
        check("flush_part_count", 64'(count), 64'd0);
        tick();

        // Bubble, then a misaligned fetch at pc 0x2.
        drive(1'b1, 32'h00510093, 64'h3000, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bubble_ready", 64'(in_ready), 64'd1);
        tick();
        idle(1'b0);
        check("bubble_count", 64'(count), 64'd0);
        tick();
        drive(1'b1, 32'h00510093, 64'h2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle(1'b1);
        check("misalign_tag", 64'(out_ctl.instr_misalign), 64'd1);
        check("misalign_pc",  out_pc, 64'h2);
        tick();

        // Randomized traffic with one asynchronous reset mid-run.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                resetn = 1'b0;
                #1;
                check("async_rst_count", 64'(count),     64'd0);
                check("async_rst_valid", 64'(out_valid), 64'd0);
                check("async_rst_ready", 64'(in_ready),  64'd0);
                q.delete();
                repeat (2) begin idle(1'b0); tick(); end
                resetn = 1'b1;
            end
            drive($urandom_range(9) < 7, rand_instr(), 64'($urandom()) << 2,
                  $urandom_range(9) != 0, $urandom_range(9) == 0,
                  $urandom_range(15) == 0, $urandom_range(9) < 6);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
